// File: rtl/axis_pkt_checker.sv
// rtl/axis_pkt_checker.sv - AXI-Stream receive checker: payload/strobe/length validation with packet and error counters
module axis_pkt_checker #(
   parameter int DATA_WIDTH = 256,
   parameter int MAX_BEATS  = 64
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic [DATA_WIDTH-1:0]   S_AXIS_TDATA,
   input  logic [DATA_WIDTH/8-1:0] S_AXIS_TSTRB,
   input  logic                    S_AXIS_TVALID,
   output logic                    S_AXIS_TREADY,
   input  logic                    S_AXIS_TLAST,
   input  logic                    count_reset,
   output logic [31:0]             rx_count,
   output logic [31:0]             err_count
);

   localparam int         LANES   = DATA_WIDTH / 32;
   localparam logic [15:0] MAX_CNT = 16'(MAX_BEATS);

   typedef enum logic {
      IDLE   = 1'b0,
      IN_PKT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] beat_cnt_q, beat_cnt_d;
   logic [15:0] exp_seq_q, exp_seq_d;
   logic [15:0] seq0_q, seq0_d;
   logic        pkt_err_q, pkt_err_d;
   logic [31:0] rx_count_q, rx_count_d;
   logic [31:0] err_count_q, err_count_d;
   logic        tready_q;

   logic             beat;
   logic             beat_err;
   logic [LANES-1:0] lane_en;
   logic [3:0]       lane_strb;
   logic [31:0]      word_idx;
   logic [15:0]      lane0_seq;

   assign beat          = S_AXIS_TVALID && tready_q;
   assign lane0_seq     = S_AXIS_TDATA[31:16];
   assign S_AXIS_TREADY = tready_q;
   assign rx_count      = rx_count_q;
   assign err_count     = err_count_q;

   // Per-beat strobe legality and payload pattern check of every strobed lane.
   // beat_cnt_q is 0 in IDLE, so it is the index of the beat being presented.
   always_comb begin
      beat_err  = 1'b0;
      lane_en   = '0;
      lane_strb = 4'h0;
      word_idx  = 32'd0;
      for (int l = 0; l < LANES; l++) begin
         lane_strb  = S_AXIS_TSTRB[4*l +: 4];
         lane_en[l] = &lane_strb;
         word_idx   = 32'(beat_cnt_q) * 32'(LANES) + 32'(l);
         if (lane_strb != 4'h0 && lane_strb != 4'hF) begin
            beat_err = 1'b1;
         end
         if (lane_en[l] && (S_AXIS_TDATA[32*l +: 32] != {exp_seq_q, word_idx[15:0]})) begin
            beat_err = 1'b1;
         end
      end
      // Set lanes must form a contiguous run starting at lane 0.
      for (int l = 1; l < LANES; l++) begin
         if (lane_en[l] && !lane_en[l-1]) begin
            beat_err = 1'b1;
         end
      end
      if (!lane_en[0]) begin
         beat_err = 1'b1;
      end
      if (!S_AXIS_TLAST && !(&S_AXIS_TSTRB)) begin
         beat_err = 1'b1;
      end
   end

   // Next-state: packet tracking, sequence resync on close, counter updates.
   always_comb begin
      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      exp_seq_d   = exp_seq_q;
      seq0_d      = seq0_q;
      pkt_err_d   = pkt_err_q;
      rx_count_d  = rx_count_q;
      err_count_d = err_count_q;
      if (count_reset) begin
         state_d     = IDLE;
         beat_cnt_d  = 16'd0;
         exp_seq_d   = 16'd0;
         pkt_err_d   = 1'b0;
         rx_count_d  = 32'd0;
         err_count_d = 32'd0;
      end else if (beat) begin
         if (S_AXIS_TLAST) begin
            rx_count_d = rx_count_q + 32'd1;
            if (pkt_err_q || beat_err) begin
               err_count_d = err_count_q + 32'd1;
            end
            pkt_err_d  = 1'b0;
            beat_cnt_d = 16'd0;
            state_d    = IDLE;
            // Resync to the sequence the sender actually used for this packet.
            exp_seq_d  = ((state_q == IDLE) ? lane0_seq : seq0_q) + 16'd1;
         end else begin
            if (state_q == IDLE) begin
               seq0_d = lane0_seq;
            end
            state_d    = IN_PKT;
            beat_cnt_d = (beat_cnt_q == MAX_CNT) ? beat_cnt_q : beat_cnt_q + 16'd1;
            // Reaching the limit without TLAST means the packet is overlong.
            pkt_err_d  = pkt_err_q || beat_err || (beat_cnt_d == MAX_CNT);
         end
      end
   end

   // Checker state and counter registers.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q     <= IDLE;
         beat_cnt_q  <= 16'd0;
         exp_seq_q   <= 16'd0;
         seq0_q      <= 16'd0;
         pkt_err_q   <= 1'b0;
         rx_count_q  <= 32'd0;
         err_count_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         beat_cnt_q  <= beat_cnt_d;
         exp_seq_q   <= exp_seq_d;
         seq0_q      <= seq0_d;
         pkt_err_q   <= pkt_err_d;
         rx_count_q  <= rx_count_d;
         err_count_q <= err_count_d;
      end
   end

   // Ready rises on the first edge out of reset and never deasserts.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         tready_q <= 1'b0;
      end else begin
         tready_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_axis_pkt_checker.sv
// tb/tb_axis_pkt_checker.sv - randomized and directed bench for axis_pkt_checker against a packet-level model
module tb_axis_pkt_checker;

   localparam int DW = 64;
   localparam int MB = 4;

   logic          ACLK = 1'b0;
   logic          ARESETN;
   logic [DW-1:0] S_AXIS_TDATA;
   logic [7:0]    S_AXIS_TSTRB;
   logic          S_AXIS_TVALID;
   logic          S_AXIS_TREADY;
   logic          S_AXIS_TLAST;
   logic          count_reset;
   logic [31:0]   rx_count;
   logic [31:0]   err_count;

   axis_pkt_checker #(.DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .S_AXIS_TDATA  (S_AXIS_TDATA),
      .S_AXIS_TSTRB  (S_AXIS_TSTRB),
      .S_AXIS_TVALID (S_AXIS_TVALID),
      .S_AXIS_TREADY (S_AXIS_TREADY),
      .S_AXIS_TLAST  (S_AXIS_TLAST),
      .count_reset   (count_reset),
      .rx_count      (rx_count),
      .err_count     (err_count)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
   } beat_t;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_rx;
   logic [31:0] m_err;
   logic [15:0] m_exp;

   function automatic beat_t mk(input logic [15:0] seq, input int b, input bit last);
      beat_t t;
      t.data = {seq, 16'(2*b+1), seq, 16'(2*b)};
      t.strb = 8'hFF;
      t.last = last;
      return t;
   endfunction

   task automatic make_pkt(input logic [15:0] seq, input int len, output beat_t p[$]);
      p = {};
      for (int b = 0; b < len; b++) p.push_back(mk(seq, b, b == len-1));
   endtask

   // Packet-level rules: length limit, legal strobe shapes, and word pattern on strobed lanes.
   function automatic bit model_err(input beat_t p[$], input logic [15:0] seq);
      bit          e;
      int          n;
      logic [31:0] want;
      e = (p.size() > MB);
      for (int i = 0; i < p.size(); i++) begin
         n = -1;
         if (!p[i].last) begin
            if (p[i].strb == 8'hFF) n = 2;
         end else begin
            for (int k = 1; k <= 2; k++)
               if (p[i].strb == 8'((1 << (4*k)) - 1)) n = k;
         end
         if (n < 0) e = 1'b1;
         else begin
            for (int l = 0; l < n; l++) begin
               want = {seq, 16'(i*2+l)};
               if (p[i].data[32*l +: 32] !== want) e = 1'b1;
            end
         end
      end
      return e;
   endfunction

   task automatic model_pkt(input beat_t p[$]);
      if (model_err(p, m_exp)) m_err = m_err + 32'd1;
      m_rx  = m_rx + 32'd1;
      m_exp = p[0].data[31:16] + 16'd1;
   endtask

   task automatic drive_pkt(input beat_t p[$], input bit gaps);
      for (int i = 0; i < p.size(); i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            S_AXIS_TVALID = 1'b0;
            S_AXIS_TDATA  = 64'($urandom);
            S_AXIS_TLAST  = 1'($urandom);
            @(negedge ACLK);
         end
         S_AXIS_TDATA  = p[i].data;
         S_AXIS_TSTRB  = p[i].strb;
         S_AXIS_TLAST  = p[i].last;
         S_AXIS_TVALID = 1'b1;
         @(negedge ACLK);
      end
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
   endtask

   task automatic clear_counts();
      count_reset = 1'b1;
      @(negedge ACLK);
      count_reset = 1'b0;
      m_rx = 0; m_err = 0; m_exp = 0;
   endtask

   task automatic test_reset();
      ARESETN = 1'b0; count_reset = 1'b0;
      S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0; S_AXIS_TDATA = '0; S_AXIS_TSTRB = '0;
      m_rx = 0; m_err = 0; m_exp = 0;
      #12;
      checks++; if (S_AXIS_TREADY !== 1'b0) begin errors++; $display("FAIL reset_tready got=%0h exp=0", S_AXIS_TREADY); end
      checks++; if (rx_count !== 32'd0) begin errors++; $display("FAIL reset_rx got=%0h exp=0", rx_count); end
      checks++; if (err_count !== 32'd0) begin errors++; $display("FAIL reset_err got=%0h exp=0", err_count); end
      @(negedge ACLK);
      ARESETN = 1'b1;
      #1;
      checks++; if (S_AXIS_TREADY !== 1'b0) begin errors++; $display("FAIL tready_before_edge got=%0h exp=0", S_AXIS_TREADY); end
      @(negedge ACLK);
      checks++; if (S_AXIS_TREADY !== 1'b1) begin errors++; $display("FAIL tready_after_edge got=%0h exp=1", S_AXIS_TREADY); end
   endtask

   task automatic test_clean();
      beat_t p[$];
      for (int s = 0; s < 3; s++) begin
         make_pkt(16'(s), 2, p);
         S_AXIS_TDATA = p[0].data; S_AXIS_TSTRB = p[0].strb; S_AXIS_TLAST = 1'b0; S_AXIS_TVALID = 1'b1;
         @(negedge ACLK);
         S_AXIS_TDATA = p[1].data; S_AXIS_TSTRB = p[1].strb; S_AXIS_TLAST = 1'b1;
         #1;
         checks++; if (rx_count !== m_rx) begin errors++; $display("FAIL clean_rx_early pkt=%0d got=%0h exp=%0h", s, rx_count, m_rx); end
         @(negedge ACLK);
         S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
         model_pkt(p);
         checks++; if (rx_count !== m_rx) begin errors++; $display("FAIL clean_rx pkt=%0d got=%0h exp=%0h", s, rx_count, m_rx); end
         checks++; if (err_count !== m_err) begin errors++; $display("FAIL clean_err pkt=%0d got=%0h exp=%0h", s, err_count, m_err); end
      end
      checks++; if (rx_count !== 32'd3) begin errors++; $display("FAIL clean_total_rx got=%0h exp=3", rx_count); end
      checks++; if (err_count !== 32'd0) begin errors++; $display("FAIL clean_total_err got=%0h exp=0", err_count); end
   endtask

   task automatic test_corrupt();
      beat_t p[$];
      clear_counts();
      make_pkt(16'd0, 2, p);
      p[1].data[63:32] = 32'h0000_0099;
      drive_pkt(p, 1'b0); model_pkt(p);
      checks++; if (err_count !== m_err || err_count !== 32'd1) begin errors++; $display("FAIL corrupt_err got=%0h exp=%0h", err_count, m_err); end
      make_pkt(16'd1, 2, p);
      drive_pkt(p, 1'b0); model_pkt(p);
      checks++; if (rx_count !== m_rx || rx_count !== 32'd2) begin errors++; $display("FAIL corrupt_next_rx got=%0h exp=%0h", rx_count, m_rx); end
      checks++; if (err_count !== 32'd1) begin errors++; $display("FAIL corrupt_next_err got=%0h exp=1", err_count); end
   endtask

   task automatic test_seq_gap();
      beat_t p[$];
      logic [15:0] seqs [3] = '{16'd0, 16'd5, 16'd6};
      logic [31:0] want_err [3] = '{32'd0, 32'd1, 32'd1};
      clear_counts();
      for (int i = 0; i < 3; i++) begin
         make_pkt(seqs[i], 2, p);
         drive_pkt(p, 1'b1); model_pkt(p);
         checks++; if (err_count !== m_err || err_count !== want_err[i]) begin errors++; $display("FAIL seq_gap_err pkt=%0d got=%0h exp=%0h", i, err_count, want_err[i]); end
      end
   endtask

   task automatic test_strobe();
      beat_t p[$];
      logic [31:0] want_err [4] = '{32'd0, 32'd1, 32'd2, 32'd3};
      clear_counts();
      for (int c = 0; c < 4; c++) begin
         make_pkt(16'(c), (c == 3) ? 6 : 2, p);
         case (c)
            0: begin p[1].strb = 8'h0F; p[1].data[63:32] = $urandom; end
            1: p[1].strb = 8'hF0;
            2: p[0].strb = 8'h0F;
            default: ;
         endcase
         drive_pkt(p, 1'b0); model_pkt(p);
         checks++; if (err_count !== m_err || err_count !== want_err[c]) begin errors++; $display("FAIL strobe_err case=%0d got=%0h exp=%0h", c, err_count, want_err[c]); end
         checks++; if (rx_count !== m_rx) begin errors++; $display("FAIL strobe_rx case=%0d got=%0h exp=%0h", c, rx_count, m_rx); end
      end
   endtask

   task automatic test_count_reset();
      beat_t p[$];
      clear_counts();
      make_pkt(16'd0, 2, p);
      drive_pkt(p, 1'b0); model_pkt(p);
      checks++; if (rx_count !== 32'd1) begin errors++; $display("FAIL cr_pre_rx got=%0h exp=1", rx_count); end
      make_pkt(16'd1, 3, p);
      for (int i = 0; i < 3; i++) begin
         S_AXIS_TDATA = p[i].data; S_AXIS_TSTRB = p[i].strb; S_AXIS_TLAST = p[i].last; S_AXIS_TVALID = 1'b1;
         count_reset = (i > 0);
         @(negedge ACLK);
      end
      S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0; count_reset = 1'b0;
      m_rx = 0; m_err = 0; m_exp = 0;
      checks++; if (rx_count !== 32'd0) begin errors++; $display("FAIL cr_rx got=%0h exp=0", rx_count); end
      checks++; if (err_count !== 32'd0) begin errors++; $display("FAIL cr_err got=%0h exp=0", err_count); end
      checks++; if (S_AXIS_TREADY !== 1'b1) begin errors++; $display("FAIL cr_tready got=%0h exp=1", S_AXIS_TREADY); end
      make_pkt(16'd0, 2, p);
      drive_pkt(p, 1'b0); model_pkt(p);
      checks++; if (rx_count !== 32'd1 || rx_count !== m_rx) begin errors++; $display("FAIL cr_post_rx got=%0h exp=1", rx_count); end
      checks++; if (err_count !== 32'd0 || err_count !== m_err) begin errors++; $display("FAIL cr_post_err got=%0h exp=0", err_count); end
   endtask

   task automatic test_random();
      beat_t p[$];
      int len, b, l;
      logic [7:0] strbs [5] = '{8'h0F, 8'hF0, 8'h00, 8'h3F, 8'hFF};
      clear_counts();
      for (int n = 0; n < 40; n++) begin
         len = $urandom_range(1, 6);
         make_pkt(($urandom_range(0, 3) == 0) ? 16'($urandom) : m_exp, len, p);
         if ($urandom_range(0, 3) == 0) begin
            b = $urandom_range(0, len-1);
            l = $urandom_range(0, 1);
            p[b].data[32*l +: 32] = p[b].data[32*l +: 32] ^ (32'd1 << $urandom_range(0, 31));
         end
         if ($urandom_range(0, 3) == 0) begin
            p[len-1].strb = strbs[$urandom_range(0, 4)];
            if (p[len-1].strb == 8'h0F) p[len-1].data[63:32] = $urandom;
         end
         drive_pkt(p, 1'b1); model_pkt(p);
         checks++; if (rx_count !== m_rx) begin errors++; $display("FAIL rand_rx pkt=%0d got=%0h exp=%0h", n, rx_count, m_rx); end
         checks++; if (err_count !== m_err) begin errors++; $display("FAIL rand_err pkt=%0d got=%0h exp=%0h", n, err_count, m_err); end
      end
   endtask

   task automatic test_wrap();
      beat_t p[$];
      force dut.rx_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.rx_count_q;
      m_rx = 32'hFFFF_FFFF;
      checks++; if (rx_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preset got=%0h exp=ffffffff", rx_count); end
      @(negedge ACLK);
      make_pkt(m_exp, 2, p);
      drive_pkt(p, 1'b0); model_pkt(p);
      checks++; if (rx_count !== 32'd0 || rx_count !== m_rx) begin errors++; $display("FAIL wrap_rx got=%0h exp=0", rx_count); end
   endtask

   task automatic test_async_reset();
      beat_t p[$];
      clear_counts();
      make_pkt(16'd0, 2, p); drive_pkt(p, 1'b0); model_pkt(p);
      make_pkt(16'd7, 2, p); drive_pkt(p, 1'b0); model_pkt(p);
      checks++; if (rx_count !== 32'd2 || err_count !== 32'd1) begin errors++; $display("FAIL ar_pre got=%0h/%0h exp=2/1", rx_count, err_count); end
      make_pkt(m_exp, 3, p);
      S_AXIS_TDATA = p[0].data; S_AXIS_TSTRB = p[0].strb; S_AXIS_TLAST = 1'b0; S_AXIS_TVALID = 1'b1;
      @(posedge ACLK);
      #2;
      ARESETN = 1'b0;
      #1;
      checks++; if (S_AXIS_TREADY !== 1'b0) begin errors++; $display("FAIL ar_tready got=%0h exp=0", S_AXIS_TREADY); end
      checks++; if (rx_count !== 32'd0) begin errors++; $display("FAIL ar_rx got=%0h exp=0", rx_count); end
      checks++; if (err_count !== 32'd0) begin errors++; $display("FAIL ar_err got=%0h exp=0", err_count); end
      @(negedge ACLK);
      S_AXIS_TVALID = 1'b0;
      ARESETN = 1'b1;
      m_rx = 0; m_err = 0; m_exp = 0;
      @(negedge ACLK);
      make_pkt(16'd0, 2, p); drive_pkt(p, 1'b0); model_pkt(p);
      checks++; if (rx_count !== 32'd1 || rx_count !== m_rx) begin errors++; $display("FAIL ar_post_rx got=%0h exp=1", rx_count); end
      checks++; if (err_count !== 32'd0 || err_count !== m_err) begin errors++; $display("FAIL ar_post_err got=%0h exp=0", err_count); end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_corrupt();
      test_seq_gap();
      test_strobe();
      test_count_reset();
      test_random();
      test_wrap();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axis_pkt_checker.md
Name: axis_pkt_checker

Overview:
- Receive-side sink of the AXI-Stream traffic generator/checker pcore.
- Consumes the looped-back stream, checks every packet against the generator's deterministic payload pattern, and produces the free-running rx_count and err_count.
- Those counts feed the AXI4-Lite register block, which samples them into its own clock domain.
- Honours the count_reset level returned from the register block.

Parameters:
- DATA_WIDTH, 256, TDATA width; must be a multiple of 32. LANES = DATA_WIDTH/32; lane 0 = TDATA[31:0].
- MAX_BEATS, 64, maximum legal packet length in beats; 1..65535.

Ports:
- ACLK  in  1  stream clock; all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- S_AXIS_TDATA  in  DATA_WIDTH  payload.
- S_AXIS_TSTRB  in  DATA_WIDTH/8  byte strobes.
- S_AXIS_TVALID  in  1  beat valid.
- S_AXIS_TREADY  out  1  beat accept.
- S_AXIS_TLAST  in  1  last beat of packet.
- count_reset  in  1  level; synchronous clear of counters and sequence.
- rx_count  out  32  packets received (registered).
- err_count  out  32  packets with at least one error (registered).

Behaviour:
- Clock and reset: one clock, ACLK; reset ARESETN is asynchronous, active-low.
- Reset values (ARESETN low, async):
  - S_AXIS_TREADY=0, rx_count=0, err_count=0.
  - Expected sequence exp_seq=0, beat counter=0, state IDLE, pkt_err=0.
  - TREADY rises on the first ACLK edge after deassertion and then stays 1 (no backpressure).
- Handshake: a beat is consumed when TVALID && TREADY.
- Payload pattern: word index w = beat*LANES + lane. Lane at index w must equal {exp_seq[15:0], w[15:0]}.
- Strobe rules:
  - Every lane is either all-0 or all-1 strobes.
  - Non-last beats must be fully strobed.
  - The last beat's set lanes must be contiguous from lane 0 and at least one lane is required.
  - Any violation sets pkt_err. Lanes with strobe 0 are not data-checked.
- State IDLE:
  - On a beat, compare against exp_seq; a mismatch in any strobed lane sets pkt_err.
  - Without TLAST, go to IN_PKT with beat counter=1.
  - With TLAST, the packet closes in that same cycle.
- State IN_PKT:
  - Each beat checks data and strobe and increments the beat counter.
  - Beat counter reaching MAX_BEATS with no TLAST sets pkt_err. The counter saturates and the state stays IN_PKT until TLAST.
- Packet close (TLAST beat):
  - Next edge: rx_count+1; err_count+1 if pkt_err or an error on the closing beat.
  - pkt_err cleared; state IDLE.
  - exp_seq resyncs to (received lane-0 seq field of beat 0) + 1, mod 2^16.
  - Latency from TLAST handshake to counter update is 1 cycle.
- Counter width: both counters wrap 0xFFFFFFFF -> 0 with no saturation.
- count_reset high, sampled each edge:
  - rx_count=0, err_count=0, exp_seq=0.
  - Any in-flight packet is discarded: state IDLE, pkt_err=0, and it is not counted even if TLAST occurs in the same cycle.
  - TREADY stays 1; beats arriving while high are dropped unchecked.
- Packet in flight when count_reset falls: remaining beats are treated as a new packet starting in IDLE. Errors there are expected and are counted.
- ARESETN mid-packet: immediate return to reset values; the partial packet is not counted.
- Outputs: rx_count and err_count are straight register outputs with no combinational path from inputs; the downstream block double-registers them.
- Idle cycles (TVALID=0) inside a packet have no effect.

Test Plan:
- Bench parameters: DATA_WIDTH=64 (LANES=2), MAX_BEATS=4.
- Reset then 3 clean packets: seq 0,1,2, each 2 beats full strobe (data {seq,0},{seq,1},{seq,2},{seq,3}) -> rx_count=3, err_count=0, each increment exactly 1 cycle after TLAST.
- Corrupt one lane: packet seq 0 with beat1 lane1 = 0x0000_0099 -> rx_count=1, err_count=1; next clean packet seq 1 -> err_count stays 1.
- Sequence gap: seq 0 then seq 5 -> err_count=1; following seq 6 -> no error (resync verified).
- Strobe cases:
  - Last beat TSTRB=8'h0F -> no error.
  - Last beat TSTRB=8'hF0 -> error.
  - Non-last beat TSTRB=8'h0F -> error.
  - 6-beat packet -> error, counted once at TLAST.
- count_reset:
  - Pulse high 2 cycles mid-packet, including a TLAST beat while high -> counters 0, that packet uncounted.
  - Then packet seq 0 -> rx_count=1, err_count=0.
- Wrap and async reset:
  - Force rx_count=0xFFFFFFFF, send 1 packet -> rx_count=0.
  - Assert ARESETN low between edges mid-packet -> TREADY=0 and counters 0 immediately, without waiting for an ACLK edge.
